trs_io_bus_ctrl: RTL
====================

# trs_io_bus_ctrl

Front-end between the raw TRS-80 expansion-bus I/O strobes and the on-chip I/O responders, including the hi-res graphics/video block. It synchronises and de-glitches the Z80 port strobes, then latches address and write data. For each bus cycle it produces exactly one `io_access` pulse with stable `trs_a`/`trs_d`/`trs_out`/`trs_in`. On claimed reads it holds the Z80 in WAIT until the responder signals data ready, then drives the data bus until the strobe ends.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flip-flops per strobe (≥2).
- `WAIT_TIMEOUT`, 63: max `clk` cycles in WAIT_DATA before forced completion (1..255).

Ports:
- `clk`  in  1  system clock.
- `srst`  in  1  synchronous reset, active-high.
- `bus_iorq_n`  in  1  Z80 IORQ, async, active-low.
- `bus_rd_n`  in  1  Z80 RD, async, active-low.
- `bus_wr_n`  in  1  Z80 WR, async, active-low.
- `bus_a`  in  9  port address, stable while IORQ low.
- `bus_d_in`  in  8  data bus input.
- `bus_d_out`  out  8  read data to Z80.
- `bus_d_oe`  out  1  data bus drive enable.
- `bus_wait_n`  out  1  Z80 WAIT, active-low.
- `trs_a`  out  9  latched address to responders.
- `trs_d`  out  8  latched write data.
- `trs_out`  out  1  active-low write-cycle qualifier.
- `trs_in`  out  1  active-low read-cycle qualifier.
- `io_access`  out  1  one-cycle strobe per bus cycle.
- `rd_claim`  in  1  responder decodes `trs_a` as a readable port (combinational from `trs_a`/`trs_in`).
- `rd_data`  in  8  responder read data, valid with `rd_rdy`.
- `rd_rdy`  in  1  responder read data valid (one-cycle pulse).
- `timeout_err`  out  1  sticky: a read timed out.

## Operation
- Strobe conditioning: `iorq&rd` and `iorq&wr` each pass through `SYNC_STAGES` flops, then a 2-sample filter. A strobe is "active" after 2 consecutive low samples and "released" on the first high sample.
- Arming: a new cycle starts only from IDLE with `armed=1`. `armed` clears on cycle start and sets when both conditioned strobes are released, so a strobe still low after reset never triggers a cycle.
- If read and write are both active, the cycle is invalid. Stay in IDLE with no outputs changed.
- States:
  - IDLE → LATCH on an active strobe.
  - LATCH: capture `bus_a`→`trs_a` and `bus_d_in`→`trs_d`; set `trs_out`=0 (write) or `trs_in`=0 (read). Go to ACCESS.
  - ACCESS: `io_access`=1 for this cycle only.
    - Write → END.
    - Read with `rd_claim`=1 → WAIT_DATA.
    - Read with `rd_claim`=0 → END; `bus_wait_n` released, bus not driven.
  - WAIT_DATA: on `rd_rdy`, latch `rd_data`→`bus_d_out` and go to DRIVE. If the cycle counter reaches `WAIT_TIMEOUT`, load 0xFF, set `timeout_err`, go to DRIVE.
  - DRIVE: `bus_d_oe`=1, `bus_wait_n`=1. On strobe release → IDLE.
  - END: on strobe release → IDLE.
- In IDLE, `trs_out` and `trs_in` return to 1. `trs_a`/`trs_d` hold their last values.
- `rd_rdy` outside WAIT_DATA is ignored.

## Timing
- Reset values: `bus_d_out`=0x00, `bus_d_oe`=0, `bus_wait_n`=1, `trs_a`=0, `trs_d`=0, `trs_out`=1, `trs_in`=1, `io_access`=0, `timeout_err`=0, state IDLE, `armed`=0. `srst` mid-cycle takes effect on the next edge, releasing WAIT and the bus immediately.
- Let E be the edge where the filtered strobe first reads active.
  - E+1: LATCH; `trs_*` valid.
  - E+2: `io_access`=1.
- Read WAIT timing:
  - `bus_wait_n` goes 0 at E+1 for every read, registered.
  - Unclaimed reads release `bus_wait_n` at E+3.
  - Claimed reads: `rd_rdy` at edge N gives `bus_d_oe`=1 and `bus_wait_n`=1 at N+1.
- Release: `bus_d_oe`=0 and `trs_in`/`trs_out`=1 one cycle after the first high filtered sample. Release latency from the bus pin is `SYNC_STAGES`+1 cycles.
- Timeout: `WAIT_TIMEOUT` cycles counted from WAIT_DATA entry; the counter saturates and never wraps.

## Structure
- Package `trs_io_pkg`: state enum (IDLE, LATCH, ACCESS, WAIT_DATA, DRIVE, END), default timeout constant, idle-bus value 8'hFF.
- Sub-module `strobe_cond`: synchroniser plus 2-sample filter, parameterised by `SYNC_STAGES`, instantiated once per conditioned strobe.

## Test plan
- Write port 0x80, data 0x5A → `trs_a`=0x080, `trs_d`=0x5A, `trs_out`=0 until release, single `io_access` at E+2, `bus_wait_n` stays 1.
- Claimed read port 0x82, `rd_rdy` with 0xC3 four cycles after `io_access` → `bus_wait_n` low from E+1 to `rd_rdy`+1, then `bus_d_out`=0xC3 with `bus_d_oe`=1 until release.
- Unclaimed read port 0x10 → `io_access` once, `bus_wait_n` released at E+3, `bus_d_oe` never 1.
- Claimed read, no `rd_rdy` → after 63 cycles `bus_d_out`=0xFF, `bus_d_oe`=1, `timeout_err`=1 sticky until `srst`.
- 1-cycle strobe glitch, or RD and WR low together → no `io_access`, state stays IDLE.
- `srst` during WAIT_DATA with strobe held low → `bus_wait_n`=1 and `bus_d_oe`=0 next cycle; no new cycle until the strobe goes high and then low again.

Source files
------------

// File: rtl/trs_io_pkg.sv
// Shared types and constants for the TRS-80 expansion-bus I/O front-end.
package trs_io_pkg;

  // Bus-cycle sequencer states.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_DRIVE     = 3'd4,
    S_END       = 3'd5
  } state_t;

  // Default number of clk cycles a claimed read may wait for its responder.
  localparam int DEFAULT_WAIT_TIMEOUT = 63;

  // Value returned to the Z80 when no responder answers in time.
  localparam logic [7:0] IDLE_BUS_VALUE = 8'hFF;

endpackage

// File: rtl/trs_io_bus_ctrl_strobe_cond.sv
// Synchroniser plus asymmetric 2-sample filter for one active-low bus strobe.
// The strobe reads "active" after two consecutive low samples and "released"
// on the first high sample. Flops reset low so that a strobe still held low
// through reset never looks released, which keeps the controller disarmed.
module strobe_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic strobe_n,
  output logic active,
  output logic released
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw strobe through the synchroniser and keep one older sample.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], strobe_n};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and filter registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign active   = ~sync_q[SYNC_STAGES-1] & ~prev_q;
  assign released = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trs_io_bus_ctrl.sv
// Front-end between raw Z80 I/O strobes and the on-chip I/O responders.
// Produces one io_access pulse per bus cycle with stable trs_* qualifiers and
// holds WAIT on claimed reads until the responder delivers data.
//
// Responder handshake: rd_claim is combinational from trs_a/trs_in and is
// sampled once, in ACCESS. rd_rdy is a one-cycle valid pulse carrying rd_data;
// it is only honoured in WAIT_DATA (there is no ready back to the responder,
// the sequencer always accepts data in that state) and is ignored elsewhere.
module trs_io_bus_ctrl
  import trs_io_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       bus_iorq_n,
  input  logic       bus_rd_n,
  input  logic       bus_wr_n,
  input  logic [8:0] bus_a,
  input  logic [7:0] bus_d_in,
  output logic [7:0] bus_d_out,
  output logic       bus_d_oe,
  output logic       bus_wait_n,
  output logic [8:0] trs_a,
  output logic [7:0] trs_d,
  output logic       trs_out,
  output logic       trs_in,
  output logic       io_access,
  input  logic       rd_claim,
  input  logic [7:0] rd_data,
  input  logic       rd_rdy,
  output logic       timeout_err,
  output state_t     dbg_state
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

  logic rd_act, rd_rel, wr_act, wr_rel, cyc_rel;

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic [8:0] trs_a_q, trs_a_d;
  logic [7:0] trs_d_q, trs_d_d;
  logic       trs_out_q, trs_out_d;
  logic       trs_in_q, trs_in_d;
  logic       io_access_q, io_access_d;
  logic       wait_n_q, wait_n_d;
  logic       d_oe_q, d_oe_d;
  logic [7:0] d_out_q, d_out_d;
  logic       tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;

  strobe_cond #(.SYNC_STAGES(SYNC_STAGES)) u_rd_cond (
    .clk      (clk),
    .srst     (srst),
    .strobe_n (bus_iorq_n | bus_rd_n),
    .active   (rd_act),
    .released (rd_rel)
  );

  strobe_cond #(.SYNC_STAGES(SYNC_STAGES)) u_wr_cond (
    .clk      (clk),
    .srst     (srst),
    .strobe_n (bus_iorq_n | bus_wr_n),
    .active   (wr_act),
    .released (wr_rel)
  );

  // Next-state and output logic for the bus-cycle sequencer.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    trs_a_d     = trs_a_q;
    trs_d_d     = trs_d_q;
    trs_out_d   = trs_out_q;
    trs_in_d    = trs_in_q;
    io_access_d = 1'b0;
    wait_n_d    = wait_n_q;
    d_oe_d      = d_oe_q;
    d_out_d     = d_out_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    // trs_in stays low for the whole of a read, so it identifies the cycle.
    cyc_rel     = trs_in_q ? wr_rel : rd_rel;

    if (rd_rel && wr_rel) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        // Exactly one strobe must be active; both together is not a cycle.
        if (armed_q && (rd_act ^ wr_act)) begin
          state_d   = S_LATCH;
          armed_d   = 1'b0;
          // Captured on entry so trs_* are already valid during LATCH.
          trs_a_d   = bus_a;
          trs_d_d   = bus_d_in;
          trs_out_d = ~wr_act;
          trs_in_d  = ~rd_act;
          wait_n_d  = ~rd_act;
        end
      end
      S_LATCH: begin
        state_d     = S_ACCESS;
        io_access_d = 1'b1;
      end
      S_ACCESS: begin
        if (!trs_in_q && rd_claim) begin
          state_d = S_WAIT_DATA;
          cnt_d   = 8'd0;
        end else begin
          state_d  = S_END;
          wait_n_d = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (rd_rdy) begin
          state_d  = S_DRIVE;
          d_out_d  = rd_data;
          d_oe_d   = 1'b1;
          wait_n_d = 1'b1;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d  = S_DRIVE;
          d_out_d  = IDLE_BUS_VALUE;
          d_oe_d   = 1'b1;
          wait_n_d = 1'b1;
          tmo_d    = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRIVE: begin
        if (cyc_rel) begin
          state_d   = S_IDLE;
          d_oe_d    = 1'b0;
          trs_out_d = 1'b1;
          trs_in_d  = 1'b1;
        end
      end
      S_END: begin
        if (cyc_rel) begin
          state_d   = S_IDLE;
          trs_out_d = 1'b1;
          trs_in_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      trs_a_q     <= 9'd0;
      trs_d_q     <= 8'd0;
      trs_out_q   <= 1'b1;
      trs_in_q    <= 1'b1;
      io_access_q <= 1'b0;
      wait_n_q    <= 1'b1;
      d_oe_q      <= 1'b0;
      d_out_q     <= 8'd0;
      tmo_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      trs_a_q     <= trs_a_d;
      trs_d_q     <= trs_d_d;
      trs_out_q   <= trs_out_d;
      trs_in_q    <= trs_in_d;
      io_access_q <= io_access_d;
      wait_n_q    <= wait_n_d;
      d_oe_q      <= d_oe_d;
      d_out_q     <= d_out_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign trs_a       = trs_a_q;
  assign trs_d       = trs_d_q;
  assign trs_out     = trs_out_q;
  assign trs_in      = trs_in_q;
  assign io_access   = io_access_q;
  assign bus_wait_n  = wait_n_q;
  assign bus_d_oe    = d_oe_q;
  assign bus_d_out   = d_out_q;
  assign timeout_err = tmo_q;
  assign dbg_state   = state_q;

endmodule
